// File: rtl/ram_sp_arb_be.sv
// ram_sp_arb_be: single-port RAM with per-lane write enables, a two-client
// (write / read) round-robin arbiter, fixed-latency read return with a valid
// strobe and an optional zero clear of the whole array after reset.
module ram_sp_arb_be #(
    parameter int ADR_WD     = 9,
    parameter int DEPTH      = 384,
    parameter int DAT_WD     = 32,
    parameter int COL_WD     = 8,
    parameter int RD_LAT     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     clr_busy_o,
    output logic                     err_o,
    input  logic                     wr_req_i,
    output logic                     wr_rdy_o,
    input  logic [ADR_WD-1:0]        wr_adr_i,
    input  logic [DAT_WD-1:0]        wr_dat_i,
    input  logic [DAT_WD/COL_WD-1:0] wr_bwe_i,
    input  logic                     rd_req_i,
    output logic                     rd_rdy_o,
    input  logic [ADR_WD-1:0]        rd_adr_i,
    output logic                     rd_val_o,
    output logic [DAT_WD-1:0]        rd_dat_o
);
    localparam int NB = DAT_WD / COL_WD;
    localparam logic [ADR_WD-1:0] CNT_LAST = ADR_WD'(DEPTH - 1);
    localparam logic [ADR_WD-1:0] CNT_ONE  = {{(ADR_WD-1){1'b0}}, 1'b1};
    localparam logic GNT_WR = 1'b0;
    localparam logic GNT_RD = 1'b1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam state_e ST_RST = (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;

    // An address is in range when it is below DEPTH (one extra bit so that
    // DEPTH = 2^ADR_WD compares correctly).
    function automatic logic in_range(input logic [ADR_WD-1:0] adr);
        return ({1'b0, adr} < (ADR_WD+1)'(DEPTH));
    endfunction

    // Control state
    state_e              state_q, state_d;
    logic [ADR_WD-1:0]   clr_cnt_q, clr_cnt_d;
    logic                clr_busy_q, clr_busy_d;
    logic                last_gnt_q, last_gnt_d;
    logic                err_q, err_d;

    // Arbitration and array port
    logic                wr_gnt_s, rd_gnt_s;
    logic                wr_in_rng_s, rd_in_rng_s;
    logic [ADR_WD-1:0]   mem_adr_s;
    logic [DAT_WD-1:0]   mem_wdat_s;
    logic [NB-1:0]       mem_bwe_s;
    logic [DAT_WD-1:0]   mem_q [DEPTH];

    // Read pipeline: raw array read, then one or two output stages
    logic [DAT_WD-1:0]   rd_raw_q, rd_raw_d;
    logic                rd_v0_q, rd_v0_d;
    logic                rd_v1_q, rd_v1_d;
    logic [DAT_WD-1:0]   rd_d1_q, rd_d1_d;
    logic                rd_v2_q, rd_v2_d;
    logic [DAT_WD-1:0]   rd_d2_q, rd_d2_d;

    assign wr_in_rng_s = in_range(wr_adr_i);
    assign rd_in_rng_s = in_range(rd_adr_i);

    // State register: FSM state, clear counter and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RST;
            clr_cnt_q  <= {ADR_WD{1'b0}};
            clr_busy_q <= (CLR_ON_RST != 0);
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    // Next-state logic: sweep the clear counter, leave CLEAR after the last word
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == CNT_LAST) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = {ADR_WD{1'b0}};
                end else begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = clr_cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                state_d   = ST_RUN;
                clr_cnt_d = clr_cnt_q;
            end
            default: begin
                state_d   = ST_RUN;
                clr_cnt_d = {ADR_WD{1'b0}};
            end
        endcase
        clr_busy_d = (state_d == ST_CLEAR);
    end

    // Output logic: grants (round-robin on contention) and array port select
    always_comb begin
        wr_gnt_s   = 1'b0;
        rd_gnt_s   = 1'b0;
        mem_adr_s  = wr_adr_i;
        mem_wdat_s = wr_dat_i;
        mem_bwe_s  = {NB{1'b0}};
        if (rst) begin
            wr_gnt_s  = 1'b0;
            rd_gnt_s  = 1'b0;
            mem_bwe_s = {NB{1'b0}};
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    mem_adr_s  = clr_cnt_q;
                    mem_wdat_s = {DAT_WD{1'b0}};
                    mem_bwe_s  = {NB{1'b1}};
                end
                ST_RUN: begin
                    if (wr_req_i && rd_req_i) begin
                        if (last_gnt_q == GNT_RD) begin
                            wr_gnt_s = 1'b1;
                        end else begin
                            rd_gnt_s = 1'b1;
                        end
                    end else begin
                        wr_gnt_s = wr_req_i;
                        rd_gnt_s = rd_req_i;
                    end
                    // Out-of-range writes complete the handshake but touch nothing
                    mem_bwe_s = wr_bwe_i & {NB{wr_gnt_s & wr_in_rng_s}};
                end
                default: begin
                    wr_gnt_s  = 1'b0;
                    rd_gnt_s  = 1'b0;
                    mem_bwe_s = {NB{1'b0}};
                end
            endcase
        end
    end

    // Array write: one port, per-lane enables, committed at the grant edge
    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (mem_bwe_s[k]) begin
                mem_q[mem_adr_s][k*COL_WD +: COL_WD] <= mem_wdat_s[k*COL_WD +: COL_WD];
            end
        end
    end

    // Next values for arbiter history, sticky error and read pipeline
    always_comb begin
        if (rd_gnt_s) begin
            last_gnt_d = GNT_RD;
        end else if (wr_gnt_s) begin
            last_gnt_d = GNT_WR;
        end else begin
            last_gnt_d = last_gnt_q;
        end

        err_d = err_q | (wr_gnt_s & ~wr_in_rng_s) | (rd_gnt_s & ~rd_in_rng_s);

        rd_raw_d = rd_raw_q;
        if (rd_gnt_s) begin
            if (rd_in_rng_s) begin
                rd_raw_d = mem_q[rd_adr_i];
            end else begin
                rd_raw_d = {DAT_WD{1'b0}};
            end
        end else begin
            rd_raw_d = rd_raw_q;
        end
        rd_v0_d = rd_gnt_s;

        // Output stages only load on a valid beat so the data holds between pulses
        rd_v1_d = rd_v0_q;
        if (rd_v0_q) begin
            rd_d1_d = rd_raw_q;
        end else begin
            rd_d1_d = rd_d1_q;
        end
        rd_v2_d = rd_v1_q;
        if (rd_v1_q) begin
            rd_d2_d = rd_d1_q;
        end else begin
            rd_d2_d = rd_d2_q;
        end
    end

    // Datapath registers; reset also flushes any read in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= GNT_RD;
            err_q      <= 1'b0;
            rd_raw_q   <= {DAT_WD{1'b0}};
            rd_v0_q    <= 1'b0;
            rd_v1_q    <= 1'b0;
            rd_d1_q    <= {DAT_WD{1'b0}};
            rd_v2_q    <= 1'b0;
            rd_d2_q    <= {DAT_WD{1'b0}};
        end else begin
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
            rd_raw_q   <= rd_raw_d;
            rd_v0_q    <= rd_v0_d;
            rd_v1_q    <= rd_v1_d;
            rd_d1_q    <= rd_d1_d;
            rd_v2_q    <= rd_v2_d;
            rd_d2_q    <= rd_d2_d;
        end
    end

    assign wr_rdy_o   = wr_gnt_s;
    assign rd_rdy_o   = rd_gnt_s;
    assign clr_busy_o = clr_busy_q;
    assign err_o      = err_q;
    assign rd_val_o   = (RD_LAT == 2) ? rd_v2_q : rd_v1_q;
    assign rd_dat_o   = (RD_LAT == 2) ? rd_d2_q : rd_d1_q;

endmodule
